pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Pipeline hazard and sequencing controller for the 8-bit, 4-register pipelined processor. It drives the `ld` (hold) and `flush` controls of the F/D, D/Ex, Ex/M and M/WB latches and the PC load enable, and produces the `has_hazard` code captured by D/Ex. It detects RAW and load-use hazards between decode sources and in-flight destinations, flushes on taken branches, and runs the halt drain/hold sequence.

## Interface
Parameters:
- `DRAIN_CYCLES`, default 2: cycles allowed for Ex/M and M/WB contents to retire after HLT reaches Ex.

Ports:
- `clk` input 1: clock.
- `reset` input 1: asynchronous, active-low reset.
- `d_ra`, `d_rb` input 2 each: source register ids of the instruction in decode.
- `d_use_ra`, `d_use_rb` input 1 each: decode actually reads the corresponding source.
- `ex_rd` input 2, `ex_RW` input 1, `ex_MR` input 1: destination, write enable and load flag of the instruction in Ex.
- `mem_rd` input 2, `mem_RW` input 1: destination and write enable of the instruction in Mem.
- `br_taken` input 1: branch unit resolved a taken branch in Ex.
- `ex_Hlt` input 1: HLT is in Ex.
- `resume` input 1: leave the halted state.
- `pc_ld` output 1: PC update enable.
- `fd_ld`, `fd_flush` output 1 each: F/D latch controls.
- `dx_ld`, `dx_flush` output 1 each: D/Ex latch controls.
- `xm_ld`, `mw_ld` output 1 each: Ex/M and M/WB latch controls.
- `has_hazard` output 2: hazard class. 00 none, 01 load-use, 10 branch flush, 11 RAW stall.
- `fwd_a`, `fwd_b` output 2 each: operand forward select. 00 register file, 01 from Ex/M, 10 from M/WB.
- `halted` output 1: core is frozen.

## Operation
- FSM states: RUN, DRAIN, HALT. Reset state is RUN with drain counter 0.
- RUN, hazard detection:
  - A match means `d_use_rX` is set, the destination's write enable is set, and the ids are equal.
  - Load-use: a match with `ex_MR=1` against `ex_rd`.
- RUN, priority:
  1. `br_taken`: `fd_flush=1`, `dx_flush=1`, `pc_ld=1`, `has_hazard=10`.
  2. `ex_Hlt`: `pc_ld=0`, `fd_ld=0`, `dx_flush=1`; next state DRAIN; counter loads `DRAIN_CYCLES-1`.
  3. Stall condition: `pc_ld=0`, `fd_ld=0`, `dx_flush=1`, with `has_hazard` set to 01 or 11.
  4. Otherwise: all `ld=1`, flushes 0, `has_hazard=00`.
- `xm_ld` and `mw_ld` are 1 in RUN.
- DRAIN:
  - `pc_ld=0`, `fd_ld=0`, `dx_flush=1`, `xm_ld=1`, `mw_ld=1`.
  - The counter decrements each cycle. When it reaches 0, next state is HALT.
  - `br_taken` is ignored in DRAIN.
- HALT:
  - All `ld` outputs are 0, flushes are 0, `halted=1`.
  - `resume=1` moves the FSM to RUN on the next cycle.
- Stalls are re-evaluated every cycle and last as long as the hazard condition holds.
- `has_hazard` and `fwd_*` are 00 in DRAIN and HALT.

## Timing
- All outputs except `halted` are combinational from the registered state and the current inputs. The latches act on the same edge, so there is zero latency.
- `halted` is registered and asserts on the first cycle in HALT.
- Load-use produces exactly one stall bubble. The dependent instruction issues on the next cycle, with forwarding from M/WB.
- A taken branch costs a two-instruction flush in the same cycle.
- The reset value of every output equals RUN with no hazard:
  - `pc_ld`, `fd_ld`, `dx_ld`, `xm_ld`, `mw_ld` are 1.
  - All other outputs are 0.
- A reset during DRAIN or HALT returns the FSM to RUN asynchronously and clears the counter.
- `resume` is ignored outside HALT.

## Configuration
- Macro: `PIPE_FORWARDING_EN`.
- Defined:
  - The stall condition is load-use only.
  - `fwd_a`/`fwd_b` select Ex/M on an Ex match and M/WB on a Mem match; the Ex match wins.
- Undefined:
  - The stall condition is any match against `ex_rd` or `mem_rd`, with `has_hazard=11`.
  - `fwd_a` and `fwd_b` are tied to 00.

## Structure
- Package `pipe_ctrl_pkg` holds:
  - the FSM state enum;
  - the `has_hazard` codes;
  - the `fwd` select codes.
- Sub-module `hazard_cmp`: one source-versus-destination comparator (use, write, id equality), instantiated 4 times.

## Test plan
- `d_ra=2`, `d_use_ra=1`, `ex_rd=2`, `ex_RW=1`, `ex_MR=1` → `pc_ld=0`, `fd_ld=0`, `dx_flush=1`, `has_hazard=01` for exactly 1 cycle; next cycle `fwd_a=10`.
- Forwarding build, `d_rb=1` matching a non-load `ex_rd=1` → no stall, `fwd_b=01`. Non-forwarding build, same stimulus → stall with `has_hazard=11`, lasting until the producer clears Mem.
- `br_taken=1` together with a load-use condition → branch wins: `fd_flush=1`, `dx_flush=1`, `pc_ld=1`, `has_hazard=10`.
- `ex_Hlt=1` → 2 DRAIN cycles with `xm_ld=1`, then `halted=1` and all `ld=0`; `resume=1` → RUN the next cycle.
- Reset asserted during DRAIN → all outputs return to reset values immediately; with `resume` held at 0, the FSM stays in RUN.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline hazard/sequencing controller: FSM states,
// has_hazard class codes and operand-forward select codes.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_DRAIN = 2'b01,
        ST_HALT  = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        HZ_NONE     = 2'b00,
        HZ_LOAD_USE = 2'b01,
        HZ_BRANCH   = 2'b10,
        HZ_RAW      = 2'b11
    } hazard_t;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_XM = 2'b01,
        FWD_MW = 2'b10
    } fwd_t;

    // The Ex stage holds the younger result, so it wins over Mem.
    function automatic fwd_t fwd_sel(input logic ex_hit, input logic mem_hit);
        if (ex_hit)
            return FWD_XM;
        else if (mem_hit)
            return FWD_MW;
        else
            return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_cmp.sv
// One decode-source versus in-flight-destination comparator.
module hazard_cmp (
    input  logic       src_use,
    input  logic [1:0] src_id,
    input  logic       dst_wr,
    input  logic [1:0] dst_id,
    output logic       hit
);

    // A dependency exists only if the source is read and the producer writes.
    always_comb begin
        hit = src_use && dst_wr && (src_id == dst_id);
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard and sequencing controller: RAW / load-use stalls, taken
// branch flush and the HLT drain/hold sequence.
// Optional feature macro: PIPE_FORWARDING_EN (operand forwarding; only
// load-use stalls remain when defined).
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int DRAIN_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] d_ra,
    input  logic [1:0] d_rb,
    input  logic       d_use_ra,
    input  logic       d_use_rb,
    input  logic [1:0] ex_rd,
    input  logic       ex_RW,
    input  logic       ex_MR,
    input  logic [1:0] mem_rd,
    input  logic       mem_RW,
    input  logic       br_taken,
    input  logic       ex_Hlt,
    input  logic       resume,
    output logic       pc_ld,
    output logic       fd_ld,
    output logic       fd_flush,
    output logic       dx_ld,
    output logic       dx_flush,
    output logic       xm_ld,
    output logic       mw_ld,
    output logic [1:0] has_hazard,
    output logic [1:0] fwd_a,
    output logic [1:0] fwd_b,
    output logic       halted
);

    localparam int CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CW-1:0] DRAIN_LOAD = CW'(DRAIN_CYCLES - 1);

    state_t        state;
    logic [CW-1:0] cnt;

    logic a_ex_hit, b_ex_hit, a_mem_hit, b_mem_hit;
    logic load_use, stall;
    fwd_t fwd_a_run, fwd_b_run;

    hazard_cmp u_cmp_a_ex (
        .src_use(d_use_ra), .src_id(d_ra), .dst_wr(ex_RW),  .dst_id(ex_rd),  .hit(a_ex_hit)
    );
    hazard_cmp u_cmp_b_ex (
        .src_use(d_use_rb), .src_id(d_rb), .dst_wr(ex_RW),  .dst_id(ex_rd),  .hit(b_ex_hit)
    );
    hazard_cmp u_cmp_a_mem (
        .src_use(d_use_ra), .src_id(d_ra), .dst_wr(mem_RW), .dst_id(mem_rd), .hit(a_mem_hit)
    );
    hazard_cmp u_cmp_b_mem (
        .src_use(d_use_rb), .src_id(d_rb), .dst_wr(mem_RW), .dst_id(mem_rd), .hit(b_mem_hit)
    );

    // Classify the decode dependency and pick forward sources.
    always_comb begin
        load_use = (a_ex_hit || b_ex_hit) && ex_MR;
`ifdef PIPE_FORWARDING_EN
        stall     = load_use;
        fwd_a_run = fwd_sel(a_ex_hit, a_mem_hit);
        fwd_b_run = fwd_sel(b_ex_hit, b_mem_hit);
`else
        stall     = a_ex_hit || b_ex_hit || a_mem_hit || b_mem_hit;
        fwd_a_run = FWD_RF;
        fwd_b_run = FWD_RF;
`endif
    end

    // Sequencing FSM: RUN -> DRAIN (counted) -> HALT -> RUN on resume.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= ST_RUN;
            cnt    <= '0;
            halted <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (!br_taken && ex_Hlt) begin
                        state <= ST_DRAIN;
                        cnt   <= DRAIN_LOAD;
                    end
                end
                ST_DRAIN: begin
                    if (cnt == '0) begin
                        state  <= ST_HALT;
                        halted <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_HALT: begin
                    if (resume) begin
                        state  <= ST_RUN;
                        halted <= 1'b0;
                    end
                end
                default: begin
                    state  <= ST_RUN;
                    halted <= 1'b0;
                end
            endcase
        end
    end

    // Latch controls from current state and inputs (same-edge action).
    always_comb begin
        pc_ld      = 1'b1;
        fd_ld      = 1'b1;
        fd_flush   = 1'b0;
        dx_ld      = 1'b1;
        dx_flush   = 1'b0;
        xm_ld      = 1'b1;
        mw_ld      = 1'b1;
        has_hazard = HZ_NONE;
        fwd_a      = FWD_RF;
        fwd_b      = FWD_RF;
        case (state)
            ST_RUN: begin
                fwd_a = fwd_a_run;
                fwd_b = fwd_b_run;
                if (br_taken) begin
                    fd_flush   = 1'b1;
                    dx_flush   = 1'b1;
                    has_hazard = HZ_BRANCH;
                end else if (ex_Hlt) begin
                    pc_ld    = 1'b0;
                    fd_ld    = 1'b0;
                    dx_flush = 1'b1;
                end else if (stall) begin
                    pc_ld      = 1'b0;
                    fd_ld      = 1'b0;
                    dx_flush   = 1'b1;
                    has_hazard = load_use ? HZ_LOAD_USE : HZ_RAW;
                end
            end
            ST_DRAIN: begin
                pc_ld    = 1'b0;
                fd_ld    = 1'b0;
                dx_flush = 1'b1;
            end
            ST_HALT: begin
                pc_ld = 1'b0;
                fd_ld = 1'b0;
                dx_ld = 1'b0;
                xm_ld = 1'b0;
                mw_ld = 1'b0;
            end
            default: begin
                pc_ld = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed table, multi-cycle
// sequences (load-use, halt, reset in drain) and a randomized run against
// a behavioural model. Honours PIPE_FORWARDING_EN like the design.
module tb_pipe_hazard_ctrl;

    localparam int DRAIN = 2;
`ifdef PIPE_FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] d_ra, d_rb, ex_rd, mem_rd;
    logic       d_use_ra, d_use_rb, ex_RW, ex_MR, mem_RW, br_taken, ex_Hlt, resume;
    logic       pc_ld, fd_ld, fd_flush, dx_ld, dx_flush, xm_ld, mw_ld, halted;
    logic [1:0] has_hazard, fwd_a, fwd_b;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.DRAIN_CYCLES(DRAIN)) dut (
        .clk(clk), .reset(reset),
        .d_ra(d_ra), .d_rb(d_rb), .d_use_ra(d_use_ra), .d_use_rb(d_use_rb),
        .ex_rd(ex_rd), .ex_RW(ex_RW), .ex_MR(ex_MR),
        .mem_rd(mem_rd), .mem_RW(mem_RW),
        .br_taken(br_taken), .ex_Hlt(ex_Hlt), .resume(resume),
        .pc_ld(pc_ld), .fd_ld(fd_ld), .fd_flush(fd_flush),
        .dx_ld(dx_ld), .dx_flush(dx_flush), .xm_ld(xm_ld), .mw_ld(mw_ld),
        .has_hazard(has_hazard), .fwd_a(fwd_a), .fwd_b(fwd_b), .halted(halted)
    );

    typedef struct {
        logic [1:0] ra, rb, exrd, memrd;
        logic       ua, ub, exrw, exmr, memrw, br, hlt, res;
    } in_t;

    typedef struct {
        string       name;
        in_t         in;
        logic [13:0] exp;
    } vec_t;

    int checks = 0;
    int errors = 0;

    // Model state: 0 running, 1 draining, 2 halted
    int   m_mode = 0;
    int   m_left = 0;
    logic m_halted = 1'b0;

    // {pc,fd,fd_flush,dx,dx_flush,xm,mw,halted,has_hazard,fwd_a,fwd_b}
    function automatic logic [13:0] mk(input logic pc, fd, fdf, dx, dxf, xm, mw, h,
                                       input logic [1:0] hh, fa, fb);
        return {pc, fd, fdf, dx, dxf, xm, mw, h, hh, fa, fb};
    endfunction

    function automatic in_t zero_in();
        in_t v;
        v.ra = '0; v.rb = '0; v.exrd = '0; v.memrd = '0;
        v.ua = 0; v.ub = 0; v.exrw = 0; v.exmr = 0; v.memrw = 0;
        v.br = 0; v.hlt = 0; v.res = 0;
        return v;
    endfunction

    function automatic logic [13:0] model_out(input in_t v, input int mode, input logic h);
        logic ea, eb, ma, mb, lu, stall;
        logic [1:0] fa, fb;
        ea = v.ua && v.exrw  && (v.ra == v.exrd);
        eb = v.ub && v.exrw  && (v.rb == v.exrd);
        ma = v.ua && v.memrw && (v.ra == v.memrd);
        mb = v.ub && v.memrw && (v.rb == v.memrd);
        lu = (ea || eb) && v.exmr;
        if (FWD) begin
            stall = lu;
            fa = ea ? 2'd1 : (ma ? 2'd2 : 2'd0);
            fb = eb ? 2'd1 : (mb ? 2'd2 : 2'd0);
        end else begin
            stall = ea || eb || ma || mb;
            fa = 2'd0;
            fb = 2'd0;
        end
        if (mode == 2) return mk(0, 0, 0, 0, 0, 0, 0, h, 2'd0, 2'd0, 2'd0);
        if (mode == 1) return mk(0, 0, 0, 1, 1, 1, 1, h, 2'd0, 2'd0, 2'd0);
        if (v.br)      return mk(1, 1, 1, 1, 1, 1, 1, h, 2'd2, fa, fb);
        if (v.hlt)     return mk(0, 0, 0, 1, 1, 1, 1, h, 2'd0, fa, fb);
        if (stall)     return mk(0, 0, 0, 1, 1, 1, 1, h, lu ? 2'd1 : 2'd3, fa, fb);
        return mk(1, 1, 0, 1, 0, 1, 1, h, 2'd0, fa, fb);
    endfunction

    task automatic model_step(input in_t v);
        case (m_mode)
            0: if (!v.br && v.hlt) begin m_mode = 1; m_left = DRAIN; end
            1: begin
                m_left = m_left - 1;
                if (m_left == 0) m_mode = 2;
            end
            default: if (v.res) m_mode = 0;
        endcase
        m_halted = (m_mode == 2);
    endtask

    task automatic drive(input in_t v);
        d_ra = v.ra; d_rb = v.rb; d_use_ra = v.ua; d_use_rb = v.ub;
        ex_rd = v.exrd; ex_RW = v.exrw; ex_MR = v.exmr;
        mem_rd = v.memrd; mem_RW = v.memrw;
        br_taken = v.br; ex_Hlt = v.hlt; resume = v.res;
    endtask

    task automatic check(input string name, input logic [13:0] exp);
        logic [13:0] act;
        act = {pc_ld, fd_ld, fd_flush, dx_ld, dx_flush, xm_ld, mw_ld, halted,
               has_hazard, fwd_a, fwd_b};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (pc fd fdf dx dxf xm mw halt hh fa fb)",
                     name, act, exp);
        end
    endtask

    // One clock: apply inputs, compare mid-cycle, advance model on the edge.
    task automatic cycle(input in_t v, input string name);
        drive(v);
        @(negedge clk);
        check(name, model_out(v, m_mode, m_halted));
        @(posedge clk);
        model_step(v);
        #1;
    endtask

    vec_t tbl[9];
    localparam logic [13:0] RST = 14'b11010110000000;

    initial begin
        in_t v;

        for (int unsigned i = 0; i < 9; i++) tbl[i].in = zero_in();
        tbl[0].name = "idle";
        tbl[0].exp  = mk(1, 1, 0, 1, 0, 1, 1, 0, 2'd0, 2'd0, 2'd0);
        tbl[1].name = "load_use_a";
        tbl[1].in.ra = 2; tbl[1].in.ua = 1; tbl[1].in.exrd = 2; tbl[1].in.exrw = 1; tbl[1].in.exmr = 1;
        tbl[1].exp  = mk(0, 0, 0, 1, 1, 1, 1, 0, 2'd1, FWD ? 2'd1 : 2'd0, 2'd0);
        tbl[2].name = "load_no_write";
        tbl[2].in.ra = 2; tbl[2].in.ua = 1; tbl[2].in.exrd = 2; tbl[2].in.exrw = 0; tbl[2].in.exmr = 1;
        tbl[2].exp  = mk(1, 1, 0, 1, 0, 1, 1, 0, 2'd0, 2'd0, 2'd0);
        tbl[3].name = "raw_ex_b";
        tbl[3].in.rb = 1; tbl[3].in.ub = 1; tbl[3].in.exrd = 1; tbl[3].in.exrw = 1;
        tbl[3].exp  = FWD ? mk(1, 1, 0, 1, 0, 1, 1, 0, 2'd0, 2'd0, 2'd1)
                          : mk(0, 0, 0, 1, 1, 1, 1, 0, 2'd3, 2'd0, 2'd0);
        tbl[4].name = "raw_mem_a";
        tbl[4].in.ra = 3; tbl[4].in.ua = 1; tbl[4].in.memrd = 3; tbl[4].in.memrw = 1;
        tbl[4].exp  = FWD ? mk(1, 1, 0, 1, 0, 1, 1, 0, 2'd0, 2'd2, 2'd0)
                          : mk(0, 0, 0, 1, 1, 1, 1, 0, 2'd3, 2'd0, 2'd0);
        tbl[5].name = "raw_ex_wins";
        tbl[5].in.ra = 3; tbl[5].in.ua = 1; tbl[5].in.exrd = 3; tbl[5].in.exrw = 1;
        tbl[5].in.memrd = 3; tbl[5].in.memrw = 1;
        tbl[5].exp  = FWD ? mk(1, 1, 0, 1, 0, 1, 1, 0, 2'd0, 2'd1, 2'd0)
                          : mk(0, 0, 0, 1, 1, 1, 1, 0, 2'd3, 2'd0, 2'd0);
        tbl[6].name = "branch_over_load_use";
        tbl[6].in = tbl[1].in; tbl[6].in.br = 1;
        tbl[6].exp  = mk(1, 1, 1, 1, 1, 1, 1, 0, 2'd2, FWD ? 2'd1 : 2'd0, 2'd0);
        tbl[7].name = "no_use";
        tbl[7].in.ra = 1; tbl[7].in.exrd = 1; tbl[7].in.exrw = 1; tbl[7].in.exmr = 1;
        tbl[7].exp  = mk(1, 1, 0, 1, 0, 1, 1, 0, 2'd0, 2'd0, 2'd0);
        tbl[8].name = "resume_in_run";
        tbl[8].in.res = 1;
        tbl[8].exp  = mk(1, 1, 0, 1, 0, 1, 1, 0, 2'd0, 2'd0, 2'd0);

        reset = 1'b0;
        drive(zero_in());
        @(negedge clk);
        check("reset_state", RST);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Directed table, all from RUN
        for (int unsigned i = 0; i < 9; i++) begin
            drive(tbl[i].in);
            @(negedge clk);
            check(tbl[i].name, tbl[i].exp);
            @(posedge clk);
            model_step(tbl[i].in);
            #1;
        end

        // Load-use bubble, then producer moves to Mem
        v = tbl[1].in;
        cycle(v, "lu_stall");
        v = zero_in(); v.ra = 2; v.ua = 1; v.memrd = 2; v.memrw = 1;
        cycle(v, "lu_issue");
        if (FWD) begin
            checks++;
            if (fwd_a !== 2'd2 || pc_ld !== 1'b1) begin
                errors++;
                $display("FAIL lu_issue_fwd: fwd_a=%0d pc_ld=%0d required fwd_a=2 pc_ld=1",
                         fwd_a, pc_ld);
            end
        end
        cycle(zero_in(), "lu_after");

        // Halt sequence: branch and resume ignored during drain
        v = zero_in(); v.hlt = 1;
        cycle(v, "hlt_in_ex");
        v = zero_in(); v.br = 1; v.res = 1;
        cycle(v, "drain_1");
        cycle(zero_in(), "drain_2");
        cycle(zero_in(), "halt_1");
        cycle(zero_in(), "halt_2");
        v = zero_in(); v.res = 1;
        cycle(v, "halt_resume");
        cycle(zero_in(), "run_after_resume");

        // Asynchronous reset in the middle of a drain cycle
        v = zero_in(); v.hlt = 1;
        cycle(v, "hlt_again");
        drive(zero_in());
        #2 reset = 1'b0;
        m_mode = 0; m_left = 0; m_halted = 1'b0;
        #1 check("reset_in_drain", RST);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        cycle(zero_in(), "run_post_reset_1");
        cycle(zero_in(), "run_post_reset_2");

        // Randomized run
        for (int unsigned n = 0; n < 400; n++) begin
            v.ra = 2'($urandom); v.rb = 2'($urandom);
            v.exrd = 2'($urandom); v.memrd = 2'($urandom);
            v.ua = 1'($urandom); v.ub = 1'($urandom);
            v.exrw = 1'($urandom); v.exmr = 1'($urandom); v.memrw = 1'($urandom);
            v.br  = ($urandom_range(0, 7) == 0);
            v.hlt = ($urandom_range(0, 15) == 0);
            v.res = ($urandom_range(0, 3) == 0);
            cycle(v, "random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
